// File: rtl/debounce_sync.sv
// ---------------------------------------------------------------------------
// debounce_sync
//
// Turns a noisy asynchronous level (switch/button) into a clean, registered
// level that is safe to feed straight into an edge detector.
//
// The raw input passes through a two-flop synchronizer. A four-state FSM
// watches the synchronized sample. A new level is accepted only after
// STABLE_CYCLES consecutive samples agree. A candidate that drops out early
// is counted as a glitch in a saturating counter.
//
// Handshake: none. D is a free-running level that the consumer may sample on
// every clock. There is no valid/ready pair on this block.
//
// Parameters
//   STABLE_CYCLES  consecutive synchronized samples needed to accept a level
//                  (2..65535)
//   GLITCH_W       width of the rejected-candidate counter
//
// Ports
//   clk          rising-edge clock for all state
//   reset        synchronous, active-high reset
//   rawIn        asynchronous noisy level; feeds only the synchronizer
//   D            clean debounced level (registered)
//   settling     high while the FSM is confirming a candidate (registered)
//   glitchCount  number of rejected candidates, saturating at all-ones
// ---------------------------------------------------------------------------
module debounce_sync #(
  parameter int STABLE_CYCLES = 16,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rawIn,
  output logic                D,
  output logic                settling,
  output logic [GLITCH_W-1:0] glitchCount
);

  // The counter is sized to hold STABLE_CYCLES. It only ever counts up to
  // STABLE_CYCLES-1, so it can never wrap.
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]       CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [GLITCH_W-1:0] G_ONE    = GLITCH_W'(1);
  localparam logic [GLITCH_W-1:0] G_MAX    = '1;

  typedef enum logic [1:0] {
    STEADY_LO  = 2'd0,
    CONFIRM_HI = 2'd1,
    STEADY_HI  = 2'd2,
    CONFIRM_LO = 2'd3
  } state_t;

  // The state register is kept under a plain name so that checkers can bind
  // to it hierarchically.
  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          d_nx;
  logic          glitch;

  logic s1;
  logic s2;

  // Two-flop synchronizer. Only s2 is used past this point.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= rawIn;
      s2 <= s1;
    end
  end

  // Next-state logic.
  // Entering a CONFIRM state loads the counter with 1, because the sample
  // that triggered the entry already counts. Confirmation happens when the
  // counter reads STABLE_CYCLES-1 and one more agreeing sample arrives. That
  // gives STABLE_CYCLES agreeing samples in total.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    d_nx     = D;
    glitch   = 1'b0;
    unique case (state)
      STEADY_LO: begin
        if (s2) begin
          state_nx = CONFIRM_HI;
          cnt_nx   = CNT_ONE;
        end
      end
      CONFIRM_HI: begin
        if (!s2) begin
          state_nx = STEADY_LO;
          cnt_nx   = '0;
          glitch   = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nx = STEADY_HI;
          cnt_nx   = '0;
          d_nx     = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      STEADY_HI: begin
        if (!s2) begin
          state_nx = CONFIRM_LO;
          cnt_nx   = CNT_ONE;
        end
      end
      CONFIRM_LO: begin
        if (s2) begin
          state_nx = STEADY_HI;
          cnt_nx   = '0;
          glitch   = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nx = STEADY_LO;
          cnt_nx   = '0;
          d_nx     = 1'b0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = STEADY_LO;
        cnt_nx   = '0;
      end
    endcase
  end

  // State and output registers.
  // settling is registered from the next state, so it tracks the state
  // register exactly. Reset takes priority over any transition, so a
  // candidate that is abandoned by reset is never counted as a glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= STEADY_LO;
      cnt         <= '0;
      D           <= 1'b0;
      settling    <= 1'b0;
      glitchCount <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      D        <= d_nx;
      settling <= (state_nx == CONFIRM_HI) || (state_nx == CONFIRM_LO);
      if (glitch && (glitchCount != G_MAX)) begin
        glitchCount <= glitchCount + G_ONE;
      end
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// ---------------------------------------------------------------------------
// tb_debounce_sync
//
// Each driven cycle pushes the expected {D, settling, glitchCount} for the
// next edge onto exp_q. The value is popped and compared 1 ns after that edge.
//
// Expectations come from the latency rules in closed form:
//   - The first edge that samples a new rawIn level is edge 1.
//   - While the candidate is being confirmed, settling is high after edges
//     3 .. h+2.
//   - A held level is accepted at edge STABLE_CYCLES+2.
//   - A pulse of h < STABLE_CYCLES cycles is rejected at edge h+3.
//
// A small edge detector on D (posEdge/negEdge counters) stands in for the
// downstream consumer.
// ---------------------------------------------------------------------------
module tb_debounce_sync;

  localparam int S  = 4;
  localparam int GW = 8;
  localparam int EW = GW + 2;
  localparam logic [GW-1:0] GMAX = '1;

  // Clock and reset.
  logic          clk = 1'b0;
  logic          reset;
  logic          rawIn;
  logic          D;
  logic          settling;
  logic [GW-1:0] glitchCount;

  always #5 clk = ~clk;

  debounce_sync #(
    .STABLE_CYCLES(S),
    .GLITCH_W     (GW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rawIn      (rawIn),
    .D          (D),
    .settling   (settling),
    .glitchCount(glitchCount)
  );

  // Scoreboard state.
  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  logic          exp_d    = 1'b0;
  logic [GW-1:0] exp_g    = '0;

  // Downstream edge detector (observed values and model values).
  logic prev_d   = 1'b0;
  logic prev_ed  = 1'b0;
  int   pos_cnt  = 0;
  int   neg_cnt  = 0;
  int   epos_cnt = 0;
  int   eneg_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, push its expectation, then compare after the edge.
  task automatic step(input logic r, input logic rst, input logic ed,
                      input logic es, input logic [GW-1:0] eg, input string tag);
    logic [EW-1:0] e;
    rawIn = r;
    reset = rst;
    exp_q.push_back({ed, es, eg});
    if (!prev_ed && ed) epos_cnt++;
    if (prev_ed && !ed) eneg_cnt++;
    prev_ed = ed;
    @(posedge clk);
    #1;
    if (prev_d === 1'b0 && D === 1'b1) pos_cnt++;
    if (prev_d === 1'b1 && D === 1'b0) neg_cnt++;
    prev_d = D;
    if (exp_q.size() == 0) begin
      check_val({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val(tag, {22'd0, D, settling, glitchCount}, {22'd0, e});
    end
  endtask

  // Driver tasks.
  task automatic reset_cycles(input int n, input logic r);
    for (int k = 0; k < n; k++) step(r, 1'b1, 1'b0, 1'b0, '0, "reset");
    exp_d   = 1'b0;
    exp_g   = '0;
    prev_ed = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(exp_d, 1'b0, exp_d, 1'b0, exp_g, "idle");
  endtask

  // Hold a new level; the pipeline must be settled at !lvl. n >= S+2.
  task automatic hold_level(input logic lvl, input int n);
    for (int k = 1; k <= n; k++)
      step(lvl, 1'b0, (k >= S + 2) ? lvl : exp_d, (k >= 3 && k <= S + 1), exp_g, "hold");
    exp_d = lvl;
  endtask

  // A pulse of h cycles (h < S) followed by tail cycles back at the old level.
  task automatic glitch(input logic lvl, input int h, input int tail);
    logic [GW-1:0] g1;
    g1 = (exp_g == GMAX) ? exp_g : exp_g + 1'b1;
    for (int k = 1; k <= h + tail; k++)
      step((k <= h) ? lvl : ~lvl, 1'b0, exp_d, (k >= 3 && k <= h + 2),
           (k >= h + 3) ? g1 : exp_g, "glitch");
    exp_g = g1;
  endtask

  initial begin
    rawIn = 1'b0;
    reset = 1'b1;

    // Reset, then a clean rise.
    reset_cycles(2, 1'b0);
    idle(3);
    hold_level(1'b1, 10);
    check_val("rise_posedge", pos_cnt, 1);

    // A clean fall. One negEdge pulse and no extra posEdge pulse.
    hold_level(1'b0, 10);
    check_val("fall_posedge", pos_cnt, 1);
    check_val("fall_negedge", neg_cnt, 1);

    // A pulse held for S-1 samples is a glitch, not a change.
    glitch(1'b1, S - 1, 4);
    check_val("glitch_one", glitchCount, 1);

    // Glitches while D is high exercise the CONFIRM_LO rejection path.
    hold_level(1'b1, 10);
    glitch(1'b0, S - 1, 4);
    glitch(1'b0, 1, 4);
    hold_level(1'b0, 10);

    // Glitches with random widths, against whichever level D currently holds.
    for (int i = 0; i < 8; i++)
      glitch(~exp_d, $urandom_range(1, S - 1), $urandom_range(3, 6));

    // Reset asserted mid-CONFIRM_HI, then released with rawIn still high.
    if (exp_d) hold_level(1'b0, 10);
    for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 1'b0, (k >= 3), exp_g, "pre_reset");
    reset_cycles(2, 1'b1);
    check_val("reset_glitch_clear", glitchCount, 0);
    hold_level(1'b1, 10);
    hold_level(1'b0, 10);

    // The glitch counter saturates.
    reset_cycles(1, 1'b0);
    idle(2);
    for (int i = 0; i < 300; i++) glitch(1'b1, 2, 3);
    check_val("glitch_saturated", glitchCount, 255);
    check_val("sat_d_low", D, 0);

    // Edge-detector totals over the whole run, and an empty scoreboard.
    check_val("total_posedge", pos_cnt, epos_cnt);
    check_val("total_negedge", neg_cnt, eneg_cnt);
    check_val("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
